// File: rtl/ahb_slave_mem.sv
// ============================================================================
// ahb_slave_mem : AHB slave over a word-addressed memory with wait states and
// OKAY/ERROR responses. Define AHB_SLV_ERR_EN to build the two-cycle ERROR path.
// Rev 1.0
// ============================================================================
`default_nettype none

module ahb_slave_mem #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH       = 16,
  parameter int          WAIT_STATES = 1
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic [31:0] Haddr,
  input  logic [1:0]  Htrans,
  input  logic        Hwrite,
  input  logic [31:0] Hwdata,
  input  logic        Hreadyin,
  output logic [31:0] Hrdata,
  output logic        Hreadyout,
  output logic [1:0]  Hresp
);

  localparam int          c_AW      = $clog2(DEPTH);
  localparam logic [31:0] c_SPAN    = 32'(4 * DEPTH);
  localparam logic [2:0]  c_WS_LOAD = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_XFER = 3'd2;
`ifdef AHB_SLV_ERR_EN
  localparam logic [2:0] S_ERR1 = 3'd3;
  localparam logic [2:0] S_ERR2 = 3'd4;
`endif

  logic [2:0]      r_state;
  logic [2:0]      w_state_nxt;
  logic [2:0]      r_cnt;
  logic [2:0]      w_cnt_nxt;
  logic [c_AW-1:0] r_idx;
  logic            r_write;
  logic            r_ok;
  logic [31:0]     r_mem [DEPTH];

  logic [31:0]     w_off;
  logic            w_ok;
  logic            w_accept;
  logic            w_mem_we;
  logic            w_unused;

  // Offset compare also rejects addresses below the base via unsigned wrap.
  assign w_off    = Haddr - BASE_ADDR;
  assign w_ok     = (w_off < c_SPAN) && (Haddr[1:0] == 2'b00);
  assign w_accept = Hreadyin && Htrans[1] && Hreadyout;
  assign w_unused = Htrans[0];

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_idx   <= '0;
      r_write <= 1'b0;
      r_ok    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_idx   <= w_off[c_AW+1:2];
        r_write <= Hwrite;
        r_ok    <= w_ok;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_WAIT: begin
        if (r_cnt == 3'd0) w_state_nxt = S_XFER;
        else               w_cnt_nxt   = r_cnt - 3'd1;
      end
`ifdef AHB_SLV_ERR_EN
      S_ERR1: w_state_nxt = S_ERR2;
`endif
      default: begin
        // IDLE, XFER and ERR2 all accept the next address phase.
        w_state_nxt = S_IDLE;
        if (w_accept) begin
          if (WAIT_STATES > 0) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = c_WS_LOAD;
          end else begin
            w_state_nxt = S_XFER;
          end
`ifdef AHB_SLV_ERR_EN
          if (!w_ok) w_state_nxt = S_ERR1;
`endif
        end
      end
    endcase
  end

  always_comb begin
    Hreadyout = 1'b1;
    Hresp     = 2'b00;
    Hrdata    = 32'h0;
    case (r_state)
      S_WAIT: Hreadyout = 1'b0;
      S_XFER: if (!r_write && r_ok) Hrdata = r_mem[r_idx];
`ifdef AHB_SLV_ERR_EN
      S_ERR1: begin
        Hreadyout = 1'b0;
        Hresp     = 2'b01;
      end
      S_ERR2: Hresp = 2'b01;
`endif
      default: ;
    endcase
  end

  assign w_mem_we = !Hreset && (r_state == S_XFER) && r_write && r_ok;

  always_ff @(posedge Hclk) begin
    if (w_mem_we) r_mem[r_idx] <= Hwdata;
  end

endmodule

`default_nettype wire

// File: tb/tb_ahb_slave_mem.sv
// ============================================================================
// tb_ahb_slave_mem : scoreboard bench for ahb_slave_mem (WAIT_STATES 1 and 0).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ahb_slave_mem;

  typedef struct {
    logic [31:0] rd;
    logic [1:0]  resp;
    int          waits;
  } exp_t;

`ifdef AHB_SLV_ERR_EN
  localparam logic [1:0] c_ERESP = 2'b01;
`else
  localparam logic [1:0] c_ERESP = 2'b00;
`endif
  localparam logic [1:0] c_IDLE = 2'b00;
  localparam logic [1:0] c_BUSY = 2'b01;
  localparam logic [1:0] c_NS   = 2'b10;
  localparam logic [1:0] c_SEQ  = 2'b11;

  logic        clk = 1'b0;
  logic        rst    [2];
  logic [31:0] haddr  [2];
  logic [1:0]  htrans [2];
  logic        hwrite [2];
  logic [31:0] hwdata [2];
  logic [31:0] hrdata [2];
  logic        hro    [2];
  logic [1:0]  hresp  [2];

  logic [31:0] pend_wd [2];
  logic        active  [2];
  logic        prv_rst [2];
  int          waits   [2];
  exp_t        q0[$];
  exp_t        q1[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ahb_slave_mem #(.BASE_ADDR(32'h8000_0000), .DEPTH(16), .WAIT_STATES(1)) u_dut0 (
    .Hclk(clk), .Hreset(rst[0]), .Haddr(haddr[0]), .Htrans(htrans[0]), .Hwrite(hwrite[0]),
    .Hwdata(hwdata[0]), .Hreadyin(hro[0]), .Hrdata(hrdata[0]), .Hreadyout(hro[0]), .Hresp(hresp[0])
  );

  ahb_slave_mem #(.BASE_ADDR(32'h8000_0000), .DEPTH(16), .WAIT_STATES(0)) u_dut1 (
    .Hclk(clk), .Hreset(rst[1]), .Haddr(haddr[1]), .Htrans(htrans[1]), .Hwrite(hwrite[1]),
    .Hwdata(hwdata[1]), .Hreadyin(hro[1]), .Hrdata(hrdata[1]), .Hreadyout(hro[1]), .Hresp(hresp[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: tracks each accepted transfer's data phase and scores it on completion.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (prv_rst[d]) begin
        chk("rst_ready", 32'(hro[d]), 32'd1);
        chk("rst_resp", 32'(hresp[d]), 32'd0);
        chk("rst_rdata", hrdata[d], 32'd0);
      end
      if (rst[d]) begin
        active[d] = 1'b0;
      end else begin
        if (active[d]) begin
          if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_empty: dut%0d completed a data phase with no expectation", d);
            active[d] = 1'b0;
          end else begin
            exp_t e;
            e = (d == 0) ? q0[0] : q1[0];
            if (!hro[d]) begin
              waits[d]++;
              chk("wait_resp", 32'(hresp[d]), 32'(e.resp));
            end else begin
              chk("rdata", hrdata[d], e.rd);
              chk("resp", 32'(hresp[d]), 32'(e.resp));
              chk("wait_cycles", 32'(waits[d]), 32'(e.waits));
              if (d == 0) void'(q0.pop_front());
              else        void'(q1.pop_front());
              active[d] = 1'b0;
            end
          end
        end
        if (hro[d] && htrans[d][1]) begin
          active[d] = 1'b1;
          waits[d]  = 0;
        end
      end
      prv_rst[d] = rst[d];
    end
  end

  task automatic bus_cycle(input int d, input logic [1:0] tr, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd_next, input logic push, input logic [31:0] erd,
                           input logic [1:0] eresp, input int ewait);
    exp_t e;
    int   n;
    hwdata[d]  = pend_wd[d];
    htrans[d]  = tr;
    hwrite[d]  = wr;
    haddr[d]   = addr;
    pend_wd[d] = wd_next;
    if (push && tr[1]) begin
      e.rd = erd; e.resp = eresp; e.waits = ewait;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    n = 0;
    forever begin
      @(negedge clk);
      if (hro[d]) break;
      n++;
      if (n > 20) begin
        n_tests++;
        n_fail++;
        $display("FAIL ready_timeout: dut%0d Hreadyout stuck at 0", d);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int d, input logic [1:0] tr, input logic [31:0] a, input logic [31:0] v,
                    input int ew, input logic [1:0] er);
    bus_cycle(d, tr, 1'b1, a, v, 1'b1, 32'h0, er, ew);
  endtask

  task automatic rd(input int d, input logic [1:0] tr, input logic [31:0] a, input logic [31:0] ev,
                    input int ew, input logic [1:0] er);
    bus_cycle(d, tr, 1'b0, a, 32'h0, 1'b1, ev, er, ew);
  endtask

  task automatic idle(input int d);
    bus_cycle(d, c_IDLE, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 2'b00, 0);
  endtask

  initial begin
    int c0;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; htrans[d] = $urandom; hwrite[d] = $urandom; haddr[d] = $urandom;
      hwdata[d] = $urandom; pend_wd[d] = 32'h0; active[d] = 1'b0; prv_rst[d] = 1'b0; waits[d] = 0;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        htrans[d] = $urandom; hwrite[d] = $urandom; haddr[d] = $urandom; hwdata[d] = $urandom;
      end
    end
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0; htrans[d] = c_IDLE; hwrite[d] = 1'b0;
    end

    // Single transfers with one wait state
    wr(0, c_NS, 32'h8000_0000, 32'hA5A5_0000, 1, 2'b00);
    wr(0, c_NS, 32'h8000_0008, 32'h1111_2222, 1, 2'b00);
    wr(0, c_NS, 32'h8000_0004, 32'hDEAD_BEEF, 1, 2'b00);
    rd(0, c_NS, 32'h8000_0004, 32'hDEAD_BEEF, 1, 2'b00);
    wr(0, c_NS, 32'h8000_003C, 32'hCAFE_F00D, 1, 2'b00);
    rd(0, c_NS, 32'h8000_003C, 32'hCAFE_F00D, 1, 2'b00);
    idle(0);

    // IDLE and BUSY with Hwrite=1 must neither stall nor write
    bus_cycle(0, c_IDLE, 1'b1, 32'h8000_0004, 32'h0BAD_0001, 1'b0, 32'h0, 2'b00, 0);
    @(negedge clk);
    chk("idle_ready", 32'(hro[0]), 32'd1);
    chk("idle_resp", 32'(hresp[0]), 32'd0);
    @(posedge clk); #1;
    bus_cycle(0, c_BUSY, 1'b1, 32'h8000_0004, 32'h0BAD_0002, 1'b0, 32'h0, 2'b00, 0);
    @(negedge clk);
    chk("busy_ready", 32'(hro[0]), 32'd1);
    chk("busy_resp", 32'(hresp[0]), 32'd0);
    chk("busy_rdata", hrdata[0], 32'd0);
    @(posedge clk); #1;
    rd(0, c_NS, 32'h8000_0004, 32'hDEAD_BEEF, 1, 2'b00);

    // Bad accesses: out of range (aliases word 0 on truncation), misaligned, below base
    wr(0, c_NS, 32'h8000_0040, 32'hBAD0_BAD0, 1, c_ERESP);
    rd(0, c_NS, 32'h8000_0002, 32'h0, 1, c_ERESP);
    rd(0, c_NS, 32'h7FFF_FFFC, 32'h0, 1, c_ERESP);
    rd(0, c_NS, 32'h8000_0000, 32'hA5A5_0000, 1, 2'b00);
    idle(0);

    // Reset during the wait state of a write aborts it
    bus_cycle(0, c_NS, 1'b1, 32'h8000_0008, 32'h0, 1'b0, 32'h0, 2'b00, 0);
    rst[0] = 1'b1; htrans[0] = c_IDLE; hwdata[0] = 32'h1234_5678;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    rd(0, c_NS, 32'h8000_0008, 32'h1111_2222, 1, 2'b00);
    idle(0);

    // Zero-wait burst on the second instance
    wr(1, c_NS,  32'h8000_0000, 32'd1, 0, 2'b00);
    wr(1, c_SEQ, 32'h8000_0004, 32'd2, 0, 2'b00);
    wr(1, c_SEQ, 32'h8000_0008, 32'd3, 0, 2'b00);
    wr(1, c_SEQ, 32'h8000_000C, 32'd4, 0, 2'b00);
    c0 = cyc;
    rd(1, c_NS,  32'h8000_0000, 32'd1, 0, 2'b00);
    rd(1, c_SEQ, 32'h8000_0004, 32'd2, 0, 2'b00);
    rd(1, c_SEQ, 32'h8000_0008, 32'd3, 0, 2'b00);
    rd(1, c_SEQ, 32'h8000_000C, 32'd4, 0, 2'b00);
    idle(1);
    chk("b2b_cycles", 32'(cyc - c0), 32'd5);

    repeat (3) @(posedge clk);
    #1;
    chk("sb0_drained", 32'(q0.size()), 32'd0);
    chk("sb1_drained", 32'(q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
